// File: rtl/rd_burst_master.sv
// rtl/rd_burst_master.sv - splits a line read into AXI4 read bursts and streams beats back
// Single clock; at most one burst outstanding; beat count, not rlast, ends each burst.
module rd_burst_master #(
  parameter int ADDR_WIDTH = 27,
  parameter int DQ_WIDTH   = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int MAX_BURST  = 64
) (
  input  logic                    ddr_clk,
  input  logic                    ddr_rst,
  input  logic                    ddr_rreq,
  input  logic [ADDR_WIDTH-1:0]   ddr_raddr,
  input  logic [LEN_WIDTH-1:0]    ddr_rd_len,
  output logic                    ddr_rrdy,
  output logic [8*DQ_WIDTH-1:0]   ddr_rdata,
  output logic                    ddr_rdata_en,
  output logic                    ddr_rdone,
  output logic                    rd_err,
  output logic [ADDR_WIDTH-1:0]   axi_araddr,
  output logic [7:0]              axi_arlen,
  output logic                    axi_arvalid,
  input  logic                    axi_arready,
  input  logic [8*DQ_WIDTH-1:0]   axi_rdata,
  input  logic                    axi_rvalid,
  input  logic                    axi_rlast,
  output logic                    axi_rready
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  localparam logic [LEN_WIDTH-1:0] MAX_BURST_LEN = LEN_WIDTH'(MAX_BURST);

  state_t                  state, state_next;
  logic [ADDR_WIDTH-1:0]   cur_addr;
  logic [LEN_WIDTH-1:0]    remain;
  logic [8:0]              burst;
  logic [7:0]              beat_cnt;

  logic                    ar_fire, beat_fire, last_beat, start_line, err_evt;
  logic                    load_ar, rdone_next;
  logic [ADDR_WIDTH-1:0]   next_araddr;
  logic [LEN_WIDTH-1:0]    next_len;
  logic [8:0]              next_burst;

  function automatic logic [8:0] clip_burst(input logic [LEN_WIDTH-1:0] len);
    return (len > MAX_BURST_LEN) ? 9'(MAX_BURST) : len[8:0];
  endfunction

  always_ff @(posedge ddr_clk) begin
    if (ddr_rst) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    ar_fire     = (state == ADDR) && axi_arready;
    beat_fire   = (state == DATA) && axi_rvalid;
    last_beat   = beat_fire && (beat_cnt == 8'd0);
    start_line  = (state == IDLE) && ddr_rreq && (ddr_rd_len != '0);
    err_evt     = (ddr_rreq && (state != IDLE)) ||
                  (beat_fire && (axi_rlast != (beat_cnt == 8'd0)));
    state_next  = state;
    load_ar     = 1'b0;
    rdone_next  = 1'b0;
    next_araddr = cur_addr;
    next_len    = remain;
    case (state)
      IDLE: begin
        if (start_line) begin
          state_next  = ADDR;
          load_ar     = 1'b1;
          next_araddr = ddr_raddr;
          next_len    = ddr_rd_len;
        end else if (ddr_rreq) begin
          state_next = DONE;
          rdone_next = 1'b1;
        end
      end
      ADDR: if (ar_fire) state_next = DATA;
      DATA: begin
        if (last_beat) begin
          if (remain != '0) begin
            state_next = ADDR;
            load_ar    = 1'b1;
          end else begin
            state_next = DONE;
          end
        end
      end
      // After data, DONE lasts two cycles so the pulse trails the final beat by one.
      DONE: begin
        if (ddr_rdone) state_next = IDLE;
        else           rdone_next = 1'b1;
      end
      default: state_next = IDLE;
    endcase
    next_burst = clip_burst(next_len);
  end

  assign ddr_rrdy    = (state == IDLE);
  assign axi_arvalid = (state == ADDR);
  assign axi_rready  = (state == DATA);

  always_ff @(posedge ddr_clk) begin
    if (ddr_rst) begin
      cur_addr     <= '0;
      remain       <= '0;
      burst        <= '0;
      beat_cnt     <= '0;
      axi_araddr   <= '0;
      axi_arlen    <= '0;
      ddr_rdata    <= '0;
      ddr_rdata_en <= 1'b0;
      ddr_rdone    <= 1'b0;
      rd_err       <= 1'b0;
    end else begin
      ddr_rdata_en <= beat_fire;
      ddr_rdone    <= rdone_next;
      if (beat_fire) ddr_rdata <= axi_rdata;
      if (err_evt)   rd_err    <= 1'b1;
      if (start_line) begin
        cur_addr <= ddr_raddr;
        remain   <= ddr_rd_len;
      end
      if (load_ar) begin
        axi_araddr <= next_araddr;
        axi_arlen  <= 8'(next_burst - 9'd1);
        burst      <= next_burst;
      end
      if (ar_fire) begin
        cur_addr <= cur_addr + (ADDR_WIDTH'(burst) << 3);
        remain   <= remain - LEN_WIDTH'(burst);
        beat_cnt <= 8'(burst - 9'd1);
      end else if (beat_fire) begin
        beat_cnt <= beat_cnt - 8'd1;
      end
    end
  end

endmodule

// File: doc/rd_burst_master.md
# rd_burst_master

Single-clock DDR read-burst engine between `rd_cell` and the DDR controller's AXI4 read channel. It accepts one line-read request (`ddr_rreq`/`ddr_raddr`/`ddr_rd_len`), splits it into AXI bursts of at most `MAX_BURST` beats, and streams the returned 256-bit beats back as `ddr_rdata`/`ddr_rdata_en`. It signals end-of-line with a single `ddr_rdone` pulse.

## Interface
- `ADDR_WIDTH`, 27: address width in DQ_WIDTH-bit word units.
- `DQ_WIDTH`, 32: DDR DQ width. Beat width is 8*DQ_WIDTH; each beat advances the address by 8.
- `LEN_WIDTH`, 16: request length width, in beats.
- `MAX_BURST`, 64: maximum beats per AXI burst, range 1..256.

Ports (`ddr_clk` only; `ddr_rst` is synchronous and active-high):
- `ddr_clk` in 1: the only clock.
- `ddr_rst` in 1: synchronous active-high reset.
- `ddr_rreq` in 1: one-cycle request strobe.
- `ddr_raddr` in ADDR_WIDTH: line start address.
- `ddr_rd_len` in LEN_WIDTH: line length in beats.
- `ddr_rrdy` out 1: high when in IDLE, meaning a request will be accepted.
- `ddr_rdata` out 8*DQ_WIDTH: registered read beat.
- `ddr_rdata_en` out 1: `ddr_rdata` is valid this cycle.
- `ddr_rdone` out 1: one-cycle pulse marking line complete.
- `rd_err` out 1: sticky error flag, cleared only by reset.
- `axi_araddr` out ADDR_WIDTH: burst address, word units.
- `axi_arlen` out 8: beats-1.
- `axi_arvalid` out 1 / `axi_arready` in 1: AR handshake.
- `axi_rdata` in 8*DQ_WIDTH; `axi_rvalid` in 1; `axi_rlast` in 1; `axi_rready` out 1: R channel.

## Operation
- States: IDLE, ADDR, DATA, DONE.
- **IDLE**:
  - `ddr_rreq`=1 with `ddr_rd_len`≠0: latch `cur_addr`=`ddr_raddr` and `remain`=`ddr_rd_len`, then go to ADDR.
  - `ddr_rreq`=1 with `ddr_rd_len`=0: go to DONE and issue no AXI traffic.
- **ADDR**:
  - `axi_arvalid`=1.
  - `burst`=min(`remain`, MAX_BURST) and `axi_arlen`=`burst`-1. Both are registered on ADDR entry and held stable until `axi_arready`.
  - On `axi_arvalid`&`axi_arready`: `cur_addr`+=8*`burst`, `remain`-=`burst`, `beat_cnt`=`burst`-1, then go to DATA.
- **DATA**:
  - `axi_rready`=1. Each accepted beat (`rvalid`&`rready`) decrements `beat_cnt`.
  - On the beat where `beat_cnt`=0: go to ADDR if `remain`≠0, otherwise go to DONE.
  - If `axi_rlast` does not equal (`beat_cnt`==0) on any accepted beat, set `rd_err`. The beat count is authoritative; `rlast` never ends a burst.
- **DONE**: assert `ddr_rdone` for one cycle, then go to IDLE.
- Data path: `ddr_rdata`<=`axi_rdata` and `ddr_rdata_en`<=`rvalid`&`rready`, one register stage. Beats are never dropped or reordered.
- Request outside IDLE: ignored and `rd_err` set; the line in flight continues unaffected.
- Widths:
  - `remain` is LEN_WIDTH bits.
  - `cur_addr` wraps modulo 2^ADDR_WIDTH with no error.
  - Bursts are not split on address boundaries.
- Reset mid-operation: return to IDLE at once. No `ddr_rdone` is issued. Any later R beats are ignored (`axi_rready`=0) until the next request.

## Timing
- Reset values: `ddr_rrdy`=1, `axi_arvalid`=0, `axi_rready`=0, `ddr_rdata_en`=0, `ddr_rdone`=0, `rd_err`=0, `axi_arlen`=0, `axi_araddr`=0, `ddr_rdata`=0.
- Request accepted at edge t: `axi_arvalid`=1 from cycle t+1, and `ddr_rrdy`=0 from t+1.
- Zero-length request at t: `ddr_rdone`=1 in cycle t+1, and `ddr_rrdy`=1 again at t+2.
- Beat accepted at edge e: `ddr_rdata_en`=1 in cycle e+1.
- Last beat of the last burst at edge e: `ddr_rdata_en` in e+1 and `ddr_rdone` in e+2, so the pulse never coincides with a data beat. `ddr_rrdy`=1 at e+3.
- Between bursts: the AR for the next burst is valid the cycle after the previous burst's last beat. At most one burst is outstanding.
- `axi_rvalid` may be deasserted between beats; no bubble rule is imposed.

## Test plan
- 180-beat line, `ddr_raddr`=0x0000100, MAX_BURST=64, `arready`=1:
  - Three ARs: (0x0000100, arlen 63), (0x0000300, 63), (0x0000500, 51).
  - 180 `ddr_rdata_en` pulses with data order preserved.
  - One `ddr_rdone` two cycles after the final beat.
- `ddr_rd_len`=0 -> no `arvalid`; `ddr_rdone` the next cycle; `rd_err`=0.
- `arready` held low 5 cycles and `rvalid` toggled 1/0 per cycle on a 10-beat line -> `araddr`/`arlen` stable throughout; exactly 10 `ddr_rdata_en`, each one cycle after its beat.
- `axi_rlast` asserted on beat 3 of a 5-beat burst -> `rd_err`=1; engine still takes all 5 beats; `ddr_rdone` is issued.
- Second `ddr_rreq` during DATA -> ignored; `rd_err`=1; the first line completes with its correct beat count.
- `ddr_rst` pulse in the middle of DATA -> next cycle shows `arvalid`=0, `rready`=0, `ddr_rrdy`=1; no `ddr_rdone`; a new 4-beat request afterwards completes normally.
